// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters and the register file write-port arbiter.
//   hold       freeze: no new grants while high
//   req_valid  per-requester write request
//   req_addr   packed dest registers, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  one-hot grant (or all zero)
//   rf_we      register file RegWrite
//   rf_waddr   register file A3
//   rf_wdata   register file WD3
//   grant_idx  index of the last accepted requester (debug)
// The master modport is the requester side; the slave modport is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  logic                      hold;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic [2:0]                grant_idx;

  modport master (
    output hold, req_valid, req_addr, req_data,
    input  req_ready, rf_we, rf_waddr, rf_wdata, grant_idx
  );

  modport slave (
    input  hold, req_valid, req_addr, req_data,
    output req_ready, rf_we, rf_waddr, rf_wdata, grant_idx
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// NUM_REQ writeback sources, followed by one registered output stage.
//   clk   clock, all state on the rising edge
//   rst   asynchronous, active-high reset
//   bus   writeback bus (slave side): requests/ready in, rf_* and grant_idx out
// The grant is combinational from req_valid; a transfer is valid && ready at
// a rising edge and shows up on rf_* one cycle later. Writes to x0 are
// accepted (they consume a grant) but leave rf_we low.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  // Requests are padded out to 8 lanes so a 3-bit index is always in range.
  logic [7:0]        valid_pad;
  logic [ADDR_W-1:0] addr_arr [8];
  logic [DATA_W-1:0] data_arr [8];

  for (genvar i = 0; i < 8; i++) begin : g_lane
    if (i < NUM_REQ) begin : g_used
      assign valid_pad[i] = bus.req_valid[i];
      assign addr_arr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
      assign data_arr[i]  = bus.req_data[i*DATA_W +: DATA_W];
    end else begin : g_unused
      assign valid_pad[i] = 1'b0;
      assign addr_arr[i]  = '0;
      assign data_arr[i]  = '0;
    end
  end

  logic [2:0] ptr;
  logic [2:0] win;
  logic [3:0] cand;
  logic       found;
  logic       xfer;
  logic [7:0] onehot;
  logic [2:0] ptr_nxt;

  // First valid requester scanning ptr, ptr+1, ... modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    cand  = 4'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!found && valid_pad[cand[2:0]]) begin
        found = 1'b1;
        win   = cand[2:0];
      end
    end
  end

  // The winner is always valid, so a raised ready bit is itself a transfer.
  assign xfer          = found && !bus.hold;
  assign onehot        = 8'd1 << win;
  assign bus.req_ready = xfer ? onehot[NUM_REQ-1:0] : '0;
  assign ptr_nxt       = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= 3'd0;
      bus.rf_we     <= 1'b0;
      bus.rf_waddr  <= '0;
      bus.rf_wdata  <= '0;
      bus.grant_idx <= 3'd0;
    end else if (xfer) begin
      ptr           <= ptr_nxt;
      bus.rf_we     <= |addr_arr[win];
      bus.rf_waddr  <= addr_arr[win];
      bus.rf_wdata  <= data_arr[win];
      bus.grant_idx <= win;
    end else begin
      bus.rf_we     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst;
  regfile_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus state
  logic          v [N];
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];
  logic          hold_r;

  // Reference model: round-robin pointer and the expected write port.
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int            m_gidx;
  int            last_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.hold = hold_r;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]           = v[i];
      bus.req_addr[i*AW +: AW]   = a[i];
      bus.req_data[i*DW +: DW]   = d[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_gidx = 0;
  endtask

  task automatic clear_req();
    hold_r = 1'b0;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; a[i] = '0; d[i] = '0;
    end
  endtask

  task automatic check_rf(input string tag);
    chk({tag, ".rf_we"},     64'(bus.rf_we),     64'(m_we));
    chk({tag, ".rf_waddr"},  64'(bus.rf_waddr),  64'(m_waddr));
    chk({tag, ".rf_wdata"},  64'(bus.rf_wdata),  64'(m_wdata));
    chk({tag, ".grant_idx"}, 64'(bus.grant_idx), 64'(m_gidx));
  endtask

  // Called shortly after a rising edge: drives inputs, checks the
  // same-cycle grant, advances one edge and checks the write port.
  task automatic cycle(input string tag);
    logic [N-1:0] exp_ready;
    apply();
    #1;
    last_g = -1;
    if (!hold_r) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (v[i] && last_g < 0) last_g = i;
      end
    end
    exp_ready = '0;
    if (last_g >= 0) exp_ready[last_g] = 1'b1;
    chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'(exp_ready));
    if (last_g >= 0) begin
      m_we    = (a[last_g] != '0);
      m_waddr = a[last_g];
      m_wdata = d[last_g];
      m_gidx  = last_g;
      m_ptr   = (last_g + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    #1;
    check_rf(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_req();
    apply();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b0;
    clear_req();
    apply();
    #2;
    do_reset();
    check_rf("reset");
    chk("reset.req_ready", 64'(bus.req_ready), 64'd0);

    // Reset mid-transfer: a write is on rf_* and another is being granted.
    v[1] = 1'b1; a[1] = 5'd9; d[1] = 32'hCAFE0001;
    cycle("pre_rst");
    v[1] = 1'b0;
    v[2] = 1'b1; a[2] = 5'd11; d[2] = 32'hCAFE0002;
    apply();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_rf("rst_async");
    @(posedge clk);
    #1;
    check_rf("rst_held");
    rst = 1'b0;
    clear_req();
    cycle("rst_after");
    chk("rst_after.no_write", 64'(bus.rf_we), 64'd0);

    // Single requester.
    v[1] = 1'b1; a[1] = 5'd5; d[1] = 32'hDEADBEEF;
    cycle("single");
    chk("single.rf_we_const",    64'(bus.rf_we),    64'd1);
    chk("single.rf_waddr_const", 64'(bus.rf_waddr), 64'd5);
    chk("single.rf_wdata_const", 64'(bus.rf_wdata), 64'hDEADBEEF);
    clear_req();

    // All three valid from ptr=0: grants 0,1,2,0,1,2.
    do_reset();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; a[i] = AW'(i + 1); d[i] = 32'hA000_0000 + DW'(i);
    end
    for (int c = 0; c < 6; c++) begin
      cycle("rr3");
      chk("rr3.grant_seq", 64'(bus.grant_idx), 64'(c % 3));
      chk("rr3.we", 64'(bus.rf_we), 64'd1);
    end
    clear_req();

    // x0 write: granted, pointer advances, rf_we stays low.
    v[0] = 1'b1; a[0] = 5'd0; d[0] = 32'h1234;
    cycle("x0");
    chk("x0.we_const", 64'(bus.rf_we), 64'd0);
    clear_req();

    // hold for 4 cycles with req2 valid, then release.
    hold_r = 1'b1;
    v[2] = 1'b1; a[2] = 5'd20; d[2] = 32'h5555AAAA;
    for (int c = 0; c < 4; c++) cycle("hold");
    hold_r = 1'b0;
    cycle("hold_rel");
    chk("hold_rel.grant_const", 64'(bus.grant_idx), 64'd2);
    clear_req();

    // Get ptr to 1, then req0 and req2 compete: req2 first, then req0.
    v[0] = 1'b1; a[0] = 5'd3; d[0] = 32'h0303;
    cycle("to_ptr1");
    v[0] = 1'b1; a[0] = 5'd7; d[0] = 32'h0707;
    v[2] = 1'b1; a[2] = 5'd7; d[2] = 32'h2727;
    cycle("pair_a");
    chk("pair_a.grant_const", 64'(bus.grant_idx), 64'd2);
    v[2] = 1'b0;
    cycle("pair_b");
    chk("pair_b.grant_const", 64'(bus.grant_idx), 64'd0);
    clear_req();

    // Randomized traffic: pending requests mostly stay put, sometimes withdraw.
    for (int c = 0; c < 400; c++) begin
      hold_r = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        if (v[i] && last_g != i) begin
          if ($urandom_range(0, 4) == 0) v[i] = 1'b0;
        end else begin
          v[i] = ($urandom_range(0, 2) != 0);
          a[i] = AW'($urandom_range(0, 31));
          d[i] = DW'($urandom);
        end
      end
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
